// File: rtl/stream_source.sv
// Arithmetic-sequence stream generator: emits cfg_count words base, base+stride, ...
// on a valid/ready interface, with abort (stop) and a one-cycle done pulse.
module stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] cfg_base,
    input  logic [DATA_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_v,
    input  logic                  dout_r,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic        [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                          dout_v_q, dout_v_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic signed [DATA_WIDTH-1:0]  stride_q, stride_d;
    logic        [CNT_WIDTH-1:0]   remain_q, remain_d;

    logic xfer;
    logic last;

    // Two's-complement stride added with natural wrap modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] wrap_add(
        input logic        [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    assign xfer = dout_v_q & dout_r;
    assign last = (remain_q == CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            dout_v_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stride_q <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            dout_v_q <= dout_v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop || (xfer && last)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d   = dout_q;
        dout_v_d = dout_v_q;
        stride_d = stride_q;
        remain_d = remain_q;
        busy_d   = (state_d == RUN);
        // done is registered off the DONE state, so it pulses in the cycle after it.
        done_d   = (state_q == DONE);
        unique case (state_q)
            IDLE: begin
                if (start && (cfg_count != '0)) begin
                    dout_d   = cfg_base;
                    dout_v_d = 1'b1;
                    stride_d = cfg_stride;
                    remain_d = cfg_count;
                end
            end
            RUN: begin
                if (stop) begin
                    dout_v_d = 1'b0;
                    remain_d = '0;
                end else if (xfer) begin
                    if (last) begin
                        dout_v_d = 1'b0;
                        remain_d = '0;
                    end else begin
                        dout_d   = wrap_add(dout_q, stride_q);
                        remain_d = remain_q - CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                dout_v_d = 1'b0;
            end
        endcase
    end

    assign dout   = dout_q;
    assign dout_v = dout_v_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: directed scenarios plus randomized sequences checked
// against an index-based model (word i = base + i*stride).
module tb_stream_source;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [DW-1:0] cfg_base;
    logic [DW-1:0] cfg_stride;
    logic [CW-1:0] cfg_count;
    logic [DW-1:0] dout;
    logic          dout_v;
    logic          dout_r;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    stream_source #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cfg_base  (cfg_base),
        .cfg_stride(cfg_stride),
        .cfg_count (cfg_count),
        .dout      (dout),
        .dout_v    (dout_v),
        .dout_r    (dout_r),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 = ready always high, 1 = random ready, 2 = ready from 5-cycle pattern pat.
    // stop_at: number of words already consumed when stop is raised (-1 = never).
    task automatic run_seq(input logic [DW-1:0] base, input logic [DW-1:0] stride,
                           input logic [CW-1:0] count, input int rmode,
                           input logic [4:0] pat, input int stop_at, input bit poke_start);
        int            sent;
        int            k;
        bit            stopped;
        bit            r;
        bit            s;
        logic [DW-1:0] exp_w;
        sent    = 0;
        k       = 0;
        stopped = 1'b0;
        cfg_base   = base;
        cfg_stride = stride;
        cfg_count  = count;
        start      = 1'b1;
        tick();
        start = 1'b0;
        while (sent < int'(count) && !stopped) begin
            exp_w = base + DW'(sent) * stride;
            chk("dout_v_run", dout_v, 1);
            chk("dout_word", dout, exp_w);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            case (rmode)
                0:       r = 1'b1;
                2:       r = pat[k % 5];
                default: r = 1'(($urandom_range(0, 1)));
            endcase
            s = (stop_at >= 0) && (sent == stop_at);
            dout_r = r;
            stop   = s;
            if (poke_start && ($urandom_range(0, 3) == 0)) begin
                start      = 1'b1;
                cfg_base   = $urandom;
                cfg_stride = $urandom;
                cfg_count  = CW'($urandom_range(1, 200));
            end
            tick();
            start = 1'b0;
            stop  = 1'b0;
            if (r) sent++;
            if (s) stopped = 1'b1;
            k++;
        end
        // Sequence over: DONE state, start offered here must be ignored.
        chk("dout_v_end", dout_v, 0);
        chk("busy_end", busy, 0);
        chk("done_pre", done, 0);
        start     = 1'b1;
        cfg_count = CW'(3);
        cfg_base  = 32'hDEAD_0000;
        tick();
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("dout_v_after", dout_v, 0);
        chk("busy_after", busy, 0);
        tick();
        chk("done_clear", done, 0);
        chk("dout_v_idle", dout_v, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        dout_r     = 1'b0;
        cfg_base   = '0;
        cfg_stride = '0;
        cfg_count  = '0;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_dout_v", dout_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle with stop pulsing: nothing may be emitted.
        for (int i = 0; i < 3; i++) begin
            stop   = 1'(i % 2);
            dout_r = 1'b1;
            tick();
            chk("idle_quiet_v", dout_v, 0);
            chk("idle_quiet_busy", busy, 0);
        end
        stop = 1'b0;

        run_seq(32'd10, 32'd3, CW'(4), 0, 5'b00000, -1, 1'b0);
        run_seq(32'd0, 32'd1, CW'(3), 2, 5'b11001, -1, 1'b0);
        run_seq(32'hFFFF_FFFE, 32'd1, CW'(3), 0, 5'b00000, -1, 1'b0);
        run_seq(32'd7, 32'd5, CW'(0), 0, 5'b00000, -1, 1'b0);
        run_seq(32'd100, 32'hFFFF_FFFC, CW'(8), 0, 5'b00000, 2, 1'b0);
        run_seq(32'd500, 32'd2, CW'(4), 0, 5'b00000, -1, 1'b0);
        run_seq(32'd1, 32'd1, CW'(255), 0, 5'b00000, -1, 1'b0);
        run_seq(32'd9, 32'd4, CW'(6), 2, 5'b00100, 1, 1'b0);

        // Reset mid-sequence while the consumer stalls.
        cfg_base   = 32'd5;
        cfg_stride = 32'd2;
        cfg_count  = CW'(6);
        dout_r     = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_v", dout_v, 1);
        chk("mid_dout", dout, 5);
        tick();
        tick();
        chk("mid_hold", dout, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", dout, 0);
        chk("async_rst_v", dout_v, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        dout_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_v", dout_v, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_done", done, 0);
        end

        for (int n = 0; n < 10; n++) begin
            int sa;
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_seq($urandom, $urandom, CW'($urandom_range(0, 15)), 1, 5'b00000, sa, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
